// File: rtl/fb_arbiter_pkg.sv
// Shared widths, queue depth and FSM encoding for the framebuffer arbiter.
package fb_arbiter_pkg;

    localparam int ADDR_RANGE  = 12;
    localparam int REG_RANGE   = 8;
    localparam int FB_WQ_DEPTH = 4;

    typedef enum logic {
        FB_S_INIT = 1'b0,
        FB_S_RUN  = 1'b1
    } fb_state_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO for pending GPU writes; full is registered so the
// producer's ready does not depend combinationally on this cycle's pop.
module fb_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PW'(1);
        if (pop)  head_d = head_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= din;
    end

    assign dout  = mem_q[head_q];
    assign empty = (count_q == '0);
    assign full  = full_q;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: fixed-latency display reads take priority,
// queued GPU writes drain in every other slot, with write-through to vga_data.
module fb_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_RANGE,
    parameter int DATA_W   = REG_RANGE,
    parameter int WQ_DEPTH = FB_WQ_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wr_stall
);
    fb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  last_addr_q, last_addr_d, rd_addr_q, rd_addr_d;
    logic               last_vld_q, last_vld_d, rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0]  vga_data_q, vga_data_d;
    logic               wr_stall_q, wr_stall_d;

    logic                     push, pop, do_read, q_empty, q_full;
    logic [ADDR_W+DATA_W-1:0] head_ent;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;

    assign wr_ready  = ~q_full & ~rst;
    assign push      = wr_valid & wr_ready;
    assign head_addr = head_ent[ADDR_W+DATA_W-1:DATA_W];
    assign head_data = head_ent[DATA_W-1:0];

    fb_wr_fifo #(.DEPTH(WQ_DEPTH), .W(ADDR_W + DATA_W)) u_wq (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({wr_addr, wr_data}),
        .dout  (head_ent),
        .empty (q_empty),
        .full  (q_full)
    );

    always_comb begin
        state_d     = FB_S_RUN;
        last_addr_d = last_addr_q;
        last_vld_d  = last_vld_q;
        rd_addr_d   = rd_addr_q;
        rd_pend_d   = 1'b0;
        wr_stall_d  = wr_valid & ~wr_ready;
        vga_data_d  = rd_pend_q ? mem_rdata : vga_data_q;
        do_read     = 1'b0;
        pop         = 1'b0;
        mem_addr    = last_addr_q;
        mem_we      = 1'b0;
        mem_wdata   = '0;

        if (state_q == FB_S_INIT || vga_addr != last_addr_q || !last_vld_q)
            do_read = 1'b1;
        else if (!q_empty)
            pop = 1'b1;

        if (do_read) begin
            mem_addr    = vga_addr;
            rd_pend_d   = 1'b1;
            rd_addr_d   = vga_addr;
            last_addr_d = vga_addr;
            last_vld_d  = 1'b1;
        end else if (pop) begin
            mem_addr  = head_addr;
            mem_we    = 1'b1;
            mem_wdata = head_data;
            // RAM hands back the pre-write value, so the popped data wins
            // over a capture of the same address.
            if (head_addr == last_addr_q && (!rd_pend_q || rd_addr_q == head_addr))
                vga_data_d = head_data;
        end

        if (rst) begin
            pop       = 1'b0;
            mem_addr  = '0;
            mem_we    = 1'b0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FB_S_INIT;
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
            rd_addr_q   <= '0;
            rd_pend_q   <= 1'b0;
            vga_data_q  <= '0;
            wr_stall_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_addr_q <= last_addr_d;
            last_vld_q  <= last_vld_d;
            rd_addr_q   <= rd_addr_d;
            rd_pend_q   <= rd_pend_d;
            vga_data_q  <= vga_data_d;
            wr_stall_q  <= wr_stall_d;
        end
    end

    assign vga_data = vga_data_q;
    assign wr_stall = wr_stall_q;

endmodule
